// File: rtl/sweep_pkg.sv
// Shared sweep types and defaults for the sweep generator and rx checker.
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKED
  } sweep_state_t;

  localparam int SWEEP_DATA_W = 16;
  localparam int SWEEP_STEP   = 1;

endpackage

// File: rtl/sweep_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sweep_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sweep_rx_checker.sv
// Ramp/sweep receive checker: SEARCH/LOCKED tracking with error capture.
// Optional capture of last mismatch enabled by SWEEP_RX_CAPTURE_EN.
module sweep_rx_checker
  import sweep_pkg::*;
#(
  parameter int DATA_W     = SWEEP_DATA_W,
  parameter int STEP       = SWEEP_STEP,
  parameter int LOCK_COUNT = 16,
  parameter int MISS_LIMIT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              on_in,
  input  logic              clear_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [DATA_W-1:0] last_bad_rx,
  output logic [DATA_W-1:0] last_bad_exp
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(MISS_LIMIT + 1);
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  logic [1:0]        rst_q;
  logic              run;
  sweep_state_t      state;
  logic [DATA_W-1:0] expected;
  logic              primed;
  logic [MW-1:0]     match_cnt;
  logic [SW-1:0]     miss_cnt;
  logic              take;
  logic              hit;
  logic              miss_ev;

  // Release of rst_n is retimed before the FSM may leave IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign run     = rst_q[1];
  assign take    = on_in && data_valid;
  assign hit     = primed && (data_in == expected);
  assign miss_ev = take && (state == ST_LOCKED)
                && (data_in != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      expected  <= '0;
      primed    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= miss_ev;
      if (!on_in) begin
        state  <= ST_IDLE;
        locked <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (run) begin
              state     <= ST_SEARCH;
              primed    <= 1'b0;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end
          end
          ST_SEARCH: begin
            if (data_valid) begin
              expected <= data_in + STEP_V;
              primed   <= 1'b1;
              if (!hit) begin
                match_cnt <= '0;
              end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (data_valid) begin
              expected <= data_in + STEP_V;
              if (!miss_ev) begin
                miss_cnt <= '0;
              end else if (miss_cnt == SW'(MISS_LIMIT - 1)) begin
                state     <= ST_SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sweep_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_in),
    .inc   (miss_ev),
    .count (err_count)
  );

  sweep_sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_in),
    .inc   (take),
    .count (word_count)
  );

`ifdef SWEEP_RX_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bad_rx  <= '0;
      last_bad_exp <= '0;
    end else if (clear_in) begin
      last_bad_rx  <= '0;
      last_bad_exp <= '0;
    end else if (miss_ev) begin
      last_bad_rx  <= data_in;
      last_bad_exp <= expected;
    end
  end
`else
  assign last_bad_rx  = '0;
  assign last_bad_exp = '0;
`endif

endmodule

// File: tb/tb_sweep_rx_checker.sv
// Randomized bench for sweep_rx_checker against a rule-level model.
module tb_sweep_rx_checker;

  localparam int DW    = 16;
  localparam int CW    = 8;
  localparam int MOD   = 1 << DW;
  localparam int SATV  = (1 << CW) - 1;
  localparam int LOCKN = 16;
  localparam int MISSN = 4;
`ifdef SWEEP_RX_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          on_in;
  logic          clear_in;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic [CW-1:0] word_count;
  logic [DW-1:0] last_bad_rx;
  logic [DW-1:0] last_bad_exp;

  sweep_rx_checker #(
    .DATA_W(DW), .STEP(1), .LOCK_COUNT(LOCKN),
    .MISS_LIMIT(MISSN), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .on_in        (on_in),
    .clear_in     (clear_in),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .word_count   (word_count),
    .last_bad_rx  (last_bad_rx),
    .last_bad_exp (last_bad_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 search, 2 locked
  int m_mode, m_exp, m_primed, m_match, m_miss;
  int m_pulse, m_err, m_words, m_rx, m_bad, m_sync;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_primed = 0; m_match = 0;
    m_miss = 0; m_pulse = 0; m_err = 0; m_words = 0;
    m_rx = 0; m_bad = 0; m_sync = 0;
  endtask

  task automatic model_edge();
    int d;
    bit run;
    d = int'(data_in);
    if (!rst_n) begin
      model_reset();
      return;
    end
    run = (m_sync >= 2);
    m_sync++;
    m_pulse = 0;
    if (on_in && data_valid && m_words < SATV) m_words++;
    if (!on_in) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (run) begin
        m_mode = 1; m_primed = 0; m_match = 0; m_miss = 0;
      end
    end else if (data_valid) begin
      if (m_mode == 1) begin
        if (m_primed && d == m_exp) begin
          m_match++;
          if (m_match == LOCKN) begin
            m_mode = 2; m_match = 0; m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
      end else if (d == m_exp) begin
        m_miss = 0;
      end else begin
        m_pulse = 1;
        if (m_err < SATV) m_err++;
        m_rx = d; m_bad = m_exp;
        m_miss++;
        if (m_miss == MISSN) begin
          m_mode = 1; m_match = 0; m_miss = 0;
        end
      end
      m_exp = (d + 1) % MOD;
      m_primed = 1;
    end
    if (clear_in) begin
      m_err = 0; m_words = 0; m_rx = 0; m_bad = 0;
    end
  endtask

  task automatic compare_all();
    check("locked", int'(locked), int'(m_mode == 2));
    check("err_pulse", int'(err_pulse), m_pulse);
    check("err_count", int'(err_count), m_err);
    check("word_count", int'(word_count), m_words);
    check("bad_rx", int'(last_bad_rx), CAP ? m_rx : 0);
    check("bad_exp", int'(last_bad_exp), CAP ? m_bad : 0);
  endtask

  task automatic cyc(input bit on, input bit v, input int d, input bit clr);
    on_in = on; data_valid = v; data_in = DW'(d); clear_in = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ramp(input int base, input int n);
    for (int k = 0; k < n; k++) cyc(1, 1, (base + k) % MOD, 0);
  endtask

  int wrong;

  initial begin
    rst_n = 1'b0; on_in = 1'b0; clear_in = 1'b0;
    data_in = '0; data_valid = 1'b0;
    model_reset();
    repeat (3) cyc(1, 1, 5, 0);
    #2 rst_n = 1'b1;
    repeat (3) cyc(1, 0, 0, 0);

    // ramp from zero: lock after the 17th sample
    for (int i = 0; i < 256; i++) begin
      cyc(1, 1, i, 0);
      if (i == 15) check("pre_lock", int'(locked), 0);
      if (i == 16) check("lock_17th", int'(locked), 1);
    end
    check("ramp_err0", int'(err_count), 0);
    check("word_sat", int'(word_count), SATV);

    // single injected error and resync
    cyc(1, 1, 'h1234, 0);
    check("inj_pulse", int'(err_pulse), 1);
    check("inj_cnt", int'(err_count), 1);
    check("inj_rx", int'(last_bad_rx), CAP ? 'h1234 : 0);
    check("inj_exp", int'(last_bad_exp), CAP ? 'h0100 : 0);
    cyc(1, 1, 'h1235, 0);
    check("resync", int'(err_pulse), 0);
    cyc(1, 0, 0, 1);
    check("clear_words", int'(word_count), 0);

    // off, then lock across the 0xFFFF wrap
    cyc(0, 1, 7, 0);
    cyc(0, 0, 0, 0);
    check("off_unlock", int'(locked), 0);
    cyc(1, 0, 0, 0);
    ramp('hFFE0, 40);
    check("wrap_lock", int'(locked), 1);
    check("wrap_err0", int'(err_count), 0);

    // four consecutive misses drop lock
    for (int i = 0; i < MISSN; i++) begin
      wrong = int'($urandom_range(0, MOD - 1));
      if (wrong == m_exp) wrong = (wrong + 7) % MOD;
      cyc(1, 1, wrong, 0);
    end
    check("miss_unlock", int'(locked), 0);
    check("miss_cnt4", int'(err_count), 4);
    wrong = int'($urandom_range(0, MOD - 1));
    for (int k = 0; k < 17; k++) begin
      if ($urandom_range(0, 3) == 0) cyc(1, 0, 0, 0);
      cyc(1, 1, (wrong + k) % MOD, 0);
    end
    check("relock", int'(locked), 1);

    // clear coincident with a mismatch
    cyc(1, 1, (m_exp + 3) % MOD, 1);
    check("clr_pulse", int'(err_pulse), 1);
    check("clr_cnt", int'(err_count), 0);

    // alternate miss/match to saturate err_count while locked
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, (m_exp + 9) % MOD, 0);
      cyc(1, 1, m_exp, 0);
    end
    check("err_sat", int'(err_count), SATV);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) != 0) ? m_exp
                                      : int'($urandom_range(0, MOD - 1)),
          ($urandom_range(0, 79) == 0));
    end

    // asynchronous reset while locked
    cyc(1, 0, 0, 0);
    ramp(int'($urandom_range(0, MOD - 1)), 20);
    check("pre_rst_lock", int'(locked), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_err", int'(err_count), 0);
    check("arst_words", int'(word_count), 0);
    check("arst_rx", int'(last_bad_rx), 0);
    model_reset();
    cyc(1, 1, 1, 0);
    cyc(1, 1, 2, 0);
    #2 rst_n = 1'b1;
    ramp(int'($urandom_range(0, MOD - 1)), 19);
    check("rst_nolock", int'(locked), 0);
    ramp(m_exp, 1);
    check("rst_relock", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_rx_checker.md
SWEEP_RX_CHECKER -- requirements
Module: sweep_rx_checker

Interface
REQ-001 Parameter DATA_W, default 16, sample word width.
REQ-002 Parameter STEP, default 1, expected increment between consecutive valid samples.
REQ-003 Parameter LOCK_COUNT, default 16, consecutive correct steps required to declare lock.
REQ-004 Parameter MISS_LIMIT, default 4, consecutive mismatches in LOCKED that force return to SEARCH.
REQ-005 Parameter CNT_W, default 32, width of err_count and word_count.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 on_in  in  1  checker enable; low forces IDLE.
REQ-009 clear_in  in  1  synchronous clear of err_count, word_count and capture registers.
REQ-010 data_in  in  DATA_W  received sweep sample, offset binary.
REQ-011 data_valid  in  1  data_in qualifier, one sample per high cycle.
REQ-012 locked  out  1  high while in LOCKED.
REQ-013 err_pulse  out  1  one-cycle strobe per mismatch detected in LOCKED.
REQ-014 err_count  out  CNT_W  saturating count of LOCKED mismatches.
REQ-015 word_count  out  CNT_W  saturating count of valid samples accepted while on_in high.
REQ-016 last_bad_rx  out  DATA_W  received value of most recent LOCKED mismatch.
REQ-017 last_bad_exp  out  DATA_W  expected value of most recent LOCKED mismatch.

Function
REQ-018 States SHALL be IDLE, SEARCH, LOCKED; state encoding internal.
REQ-019 IDLE->SEARCH on on_in high; any state->IDLE on on_in low, effective next cycle; counters hold, not cleared.
REQ-020 In SEARCH, the first valid sample SHALL load expected = sample + STEP, match count 0.
REQ-021 In SEARCH, valid sample == expected SHALL increment match count; mismatch SHALL zero match count and reload expected from current sample + STEP.
REQ-022 Match count reaching LOCK_COUNT SHALL transition to LOCKED; locked asserts in the following cycle.
REQ-023 Expected SHALL wrap modulo 2^DATA_W (0xFFFF + 1 = 0x0000 is a match).
REQ-024 In LOCKED, mismatch SHALL pulse err_pulse, increment err_count, capture last_bad_rx/last_bad_exp, and resync expected to sample + STEP.
REQ-025 MISS_LIMIT consecutive LOCKED mismatches SHALL return to SEARCH with match count 0; one match resets the miss count.
REQ-026 Cycles with data_valid low SHALL not advance expected, counts or state.
REQ-027 All outputs SHALL be registered; latency from sample clock edge to err_pulse/counter update is one cycle.
REQ-028 err_count and word_count SHALL saturate at all-ones, never wrap.
REQ-029 clear_in coincident with an error or valid sample: clear wins; counters read 0 next cycle, err_pulse still asserts.
REQ-030 clear_in SHALL not change state or expected value.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, locked=0, err_pulse=0, err_count=0, word_count=0, last_bad_rx=0, last_bad_exp=0, match and miss counts 0.
REQ-032 Deassertion SHALL be synchronized to clk before state leaves IDLE.
REQ-033 Reset mid-LOCKED SHALL discard lock; relock requires full LOCK_COUNT again.

Configuration
REQ-034 Macro SWEEP_RX_CAPTURE_EN defined: last_bad_rx/last_bad_exp capture per REQ-024.
REQ-035 Macro undefined: capture registers omitted, last_bad_rx and last_bad_exp tied to 0; all other behaviour identical.

Structure
REQ-036 Shared package sweep_pkg SHALL hold the state enum type and default DATA_W/STEP constants, shared with the sweep generator.
REQ-037 One sub-module sweep_sat_counter (saturating counter with clear and increment) SHALL implement err_count and word_count.

Verification
REQ-038 Ramp 0x0000..0x0020 valid every cycle, on_in=1 -> locked high after 17th sample + 1 cycle, err_count=0.
REQ-039 Locked ramp through 0xFFFE,0xFFFF,0x0000,0x0001 -> no err_pulse, locked stays high.
REQ-040 Locked, inject 0x1234 where 0x0100 expected -> one err_pulse, err_count=1, last_bad_rx=0x1234, last_bad_exp=0x0100; next sample 0x1235 matches.
REQ-041 Locked, 4 consecutive random mismatches -> err_count=4, locked low, SEARCH; 16 further correct steps relock.
REQ-042 clear_in asserted same cycle as a mismatch -> err_pulse=1, err_count=0 next cycle.
REQ-043 rst_n pulsed low mid-LOCKED, asynchronous to clk -> all outputs 0 immediately; relock after 16 correct steps.
